// File: rtl/video_fill_pkg.sv
// video_fill_pkg: shared FSM state type, register map offsets and default frame geometry
// for the video fill engine.
package video_fill_pkg;

    localparam int HMAX_DEF = 640;
    localparam int VMAX_DEF = 480;

    localparam logic [1:0] REG_ORIGIN = 2'd0;
    localparam logic [1:0] REG_SIZE   = 2'd1;
    localparam logic [1:0] REG_COLOR  = 2'd2;
    localparam logic [1:0] REG_CTRL   = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETUP,
        ST_RUN,
        ST_DONE
    } fill_state_e;

endpackage

// File: rtl/video_fill_regs.sv
// video_fill_regs: register file of the fill engine (origin, size, color) plus the
// control-write strobes and the combinational read-back mux.
module video_fill_regs
    import video_fill_pkg::*;
#(
    parameter int DW = 9
) (
    input  logic          clk_sys,
    input  logic          reset_sys,
    input  logic          fill_cs,
    input  logic          fill_wr,
    input  logic [1:0]    fill_addr,
    input  logic [31:0]   fill_wr_data,
    output logic [31:0]   fill_rd_data,
    input  logic          busy,
    input  logic          done_irq,
    input  logic          aborted,
    output logic [9:0]    x0,
    output logic [8:0]    y0,
    output logic [9:0]    w,
    output logic [8:0]    h,
    output logic [DW-1:0] color,
    output logic          go_stb,
    output logic          abort_stb,
    output logic          clr_stb
);

    logic wr_en;
    logic ctrl_wr;
    logic unused_wr_bits;

    assign wr_en          = fill_cs && fill_wr;
    assign ctrl_wr        = wr_en && (fill_addr == REG_CTRL);
    assign go_stb         = ctrl_wr && fill_wr_data[0];
    assign abort_stb      = ctrl_wr && fill_wr_data[1];
    assign clr_stb        = ctrl_wr && fill_wr_data[2];
    assign unused_wr_bits = ^fill_wr_data;

    always_ff @(posedge clk_sys) begin
        if (reset_sys) begin
            x0    <= '0;
            y0    <= '0;
            w     <= '0;
            h     <= '0;
            color <= '0;
        end else if (wr_en) begin
            case (fill_addr)
                REG_ORIGIN: begin
                    x0 <= fill_wr_data[9:0];
                    y0 <= fill_wr_data[24:16];
                end
                REG_SIZE: begin
                    w <= fill_wr_data[9:0];
                    h <= fill_wr_data[24:16];
                end
                REG_COLOR: color <= fill_wr_data[DW-1:0];
                default: ;
            endcase
        end
    end

    always_comb begin
        fill_rd_data = '0;
        case (fill_addr)
            REG_ORIGIN: begin
                fill_rd_data[24:16] = y0;
                fill_rd_data[9:0]   = x0;
            end
            REG_SIZE: begin
                fill_rd_data[24:16] = h;
                fill_rd_data[9:0]   = w;
            end
            REG_COLOR: fill_rd_data[DW-1:0] = color;
            default:   fill_rd_data[2:0]    = {aborted, done_irq, busy};
        endcase
    end

endmodule

// File: rtl/video_fill_engine.sv
// video_fill_engine: rectangle fill into the video frame buffer, yielding the bus to the CPU.
// Define FILL_CLIP_EN to clip off-frame pixels instead of rejecting out-of-frame fills.
module video_fill_engine
    import video_fill_pkg::*;
#(
    parameter int HMAX = HMAX_DEF,
    parameter int VMAX = VMAX_DEF,
    parameter int DW   = 9
) (
    input  logic        clk_sys,
    input  logic        reset_sys,
    input  logic        cpu_cs,
    input  logic        cpu_wr,
    input  logic [20:0] cpu_addr,
    input  logic [31:0] cpu_wr_data,
    input  logic        fill_cs,
    input  logic        fill_wr,
    input  logic [1:0]  fill_addr,
    input  logic [31:0] fill_wr_data,
    output logic [31:0] fill_rd_data,
    output logic        video_cs,
    output logic        video_wr,
    output logic [20:0] video_addr,
    output logic [31:0] video_wr_data,
    output logic        busy,
    output logic        done_irq
);

    localparam logic [19:0] HMAX_A = 20'(HMAX);

    fill_state_e   state;
    logic          aborted;
    logic [9:0]    x0, w;
    logic [8:0]    y0, h;
    logic [DW-1:0] color;
    logic          go_stb, abort_stb, clr_stb;

    logic [19:0]   addr_p1, step_p1;
    logic [10:0]   x_p1, x0_p1, xlast_p1;
    logic [9:0]    y_p1, ylast_p1;
    logic [DW-1:0] color_p1;
    logic          vld_p1;
    logic          last_col, last_pix;

    // Constant HMAX folds this into a fixed set of shifted adds.
    function automatic logic [19:0] mul_hmax(input logic [8:0] y);
        logic [19:0] acc;
        acc = '0;
        for (int i = 0; i < 20; i++)
            if (HMAX_A[i]) acc = acc + (20'(y) << i);
        return acc;
    endfunction

    video_fill_regs #(.DW(DW)) u_regs (
        .clk_sys      (clk_sys),
        .reset_sys    (reset_sys),
        .fill_cs      (fill_cs),
        .fill_wr      (fill_wr),
        .fill_addr    (fill_addr),
        .fill_wr_data (fill_wr_data),
        .fill_rd_data (fill_rd_data),
        .busy         (busy),
        .done_irq     (done_irq),
        .aborted      (aborted),
        .x0           (x0),
        .y0           (y0),
        .w            (w),
        .h            (h),
        .color        (color),
        .go_stb       (go_stb),
        .abort_stb    (abort_stb),
        .clr_stb      (clr_stb)
    );

    assign last_col = (x_p1 == xlast_p1);
    assign last_pix = last_col && (y_p1 == ylast_p1);

`ifdef FILL_CLIP_EN
    assign vld_p1 = (state == ST_RUN) && (x_p1 < 11'(HMAX)) && (y_p1 < 10'(VMAX));
`else
    logic oob;
    assign oob    = (({1'b0, x0} + {1'b0, w}) > 11'(HMAX)) ||
                    (({1'b0, y0} + {1'b0, h}) > 10'(VMAX));
    assign vld_p1 = (state == ST_RUN);
`endif

    always_ff @(posedge clk_sys) begin
        if (reset_sys) begin
            state    <= ST_IDLE;
            busy     <= 1'b0;
            done_irq <= 1'b0;
            aborted  <= 1'b0;
        end else begin
            if (clr_stb) done_irq <= 1'b0;
            if (abort_stb && state != ST_IDLE) begin
                state   <= ST_IDLE;
                busy    <= 1'b0;
                aborted <= 1'b1;
            end else begin
                unique case (state)
                    ST_IDLE: begin
                        if (go_stb && !abort_stb) begin
`ifdef FILL_CLIP_EN
                            state   <= ST_SETUP;
                            busy    <= 1'b1;
                            aborted <= 1'b0;
`else
                            if (oob) begin
                                aborted <= 1'b1;
                            end else begin
                                state   <= ST_SETUP;
                                busy    <= 1'b1;
                                aborted <= 1'b0;
                            end
`endif
                        end
                    end
                    ST_SETUP: state <= (w == '0 || h == '0) ? ST_DONE : ST_RUN;
                    ST_RUN:   if (!cpu_cs && last_pix) state <= ST_DONE;
                    ST_DONE: begin
                        state    <= ST_IDLE;
                        busy     <= 1'b0;
                        done_irq <= 1'b1;
                    end
                endcase
            end
        end
    end

    // Stage p1: geometry latched in SETUP, then walked one pixel per unstalled RUN cycle
    always_ff @(posedge clk_sys) begin
        if (state == ST_SETUP) begin
            addr_p1  <= mul_hmax(y0) + 20'(x0);
            step_p1  <= HMAX_A + 20'd1 - 20'(w);
            x_p1     <= {1'b0, x0};
            x0_p1    <= {1'b0, x0};
            xlast_p1 <= {1'b0, x0} + {1'b0, w} - 11'd1;
            y_p1     <= {1'b0, y0};
            ylast_p1 <= {1'b0, y0} + {1'b0, h} - 10'd1;
            color_p1 <= color;
        end else if (state == ST_RUN && !cpu_cs) begin
            if (!last_col) begin
                x_p1    <= x_p1 + 11'd1;
                addr_p1 <= addr_p1 + 20'd1;
            end else begin
                x_p1    <= x0_p1;
                y_p1    <= y_p1 + 10'd1;
                addr_p1 <= addr_p1 + step_p1;
            end
        end
    end

    always_comb begin
        if (cpu_cs) begin
            video_cs      = 1'b1;
            video_wr      = cpu_wr;
            video_addr    = cpu_addr;
            video_wr_data = cpu_wr_data;
        end else begin
            video_cs      = vld_p1;
            video_wr      = vld_p1;
            video_addr    = vld_p1 ? {1'b1, addr_p1} : '0;
            video_wr_data = vld_p1 ? 32'(color_p1) : '0;
        end
    end

endmodule

// File: tb/tb_video_fill_engine.sv
// tb_video_fill_engine: directed and randomized fills; expected pixel writes come from a
// rectangle-walk reference model and are matched in order by a bus monitor.
`timescale 1ns/1ps
module tb_video_fill_engine;
    import video_fill_pkg::*;

    localparam int HMAX = 640;
    localparam int VMAX = 480;
    localparam int DW   = 9;

    logic        clk_sys = 1'b0;
    logic        reset_sys;
    logic        cpu_cs, cpu_wr;
    logic [20:0] cpu_addr;
    logic [31:0] cpu_wr_data;
    logic        fill_cs, fill_wr;
    logic [1:0]  fill_addr;
    logic [31:0] fill_wr_data, fill_rd_data;
    logic        video_cs, video_wr;
    logic [20:0] video_addr;
    logic [31:0] video_wr_data;
    logic        busy, done_irq;

    always #5 clk_sys = ~clk_sys;

    video_fill_engine #(.HMAX(HMAX), .VMAX(VMAX), .DW(DW)) dut (
        .clk_sys       (clk_sys),
        .reset_sys     (reset_sys),
        .cpu_cs        (cpu_cs),
        .cpu_wr        (cpu_wr),
        .cpu_addr      (cpu_addr),
        .cpu_wr_data   (cpu_wr_data),
        .fill_cs       (fill_cs),
        .fill_wr       (fill_wr),
        .fill_addr     (fill_addr),
        .fill_wr_data  (fill_wr_data),
        .fill_rd_data  (fill_rd_data),
        .video_cs      (video_cs),
        .video_wr      (video_wr),
        .video_addr    (video_addr),
        .video_wr_data (video_wr_data),
        .busy          (busy),
        .done_irq      (done_irq)
    );

    typedef struct {
        logic [20:0] addr;
        logic [31:0] data;
    } pix_t;

    pix_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   n_wr    = 0;
    int   n_cpu   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every engine write must be the next pixel the model predicted
    always @(negedge clk_sys) begin
        if (!reset_sys) begin
            if (cpu_cs) begin
                n_cpu++;
                check("cpu_mirror", {video_cs, video_wr, video_addr, video_wr_data},
                      {1'b1, cpu_wr, cpu_addr, cpu_wr_data});
            end else if (video_cs || video_wr) begin
                n_wr++;
                if (exp_q.size() == 0) begin
                    check("unexpected_write", {video_cs, video_wr, video_addr}, 64'd0);
                end else begin
                    pix_t p;
                    p = exp_q.pop_front();
                    check("pixel_write", {video_cs, video_wr, video_addr, video_wr_data},
                          {1'b1, 1'b1, p.addr, p.data});
                end
            end
        end
    end

    // Reference: walk the rectangle row by row, keeping on-frame pixels
    task automatic model_fill(input int x0, input int y0, input int w, input int h,
                              input logic [DW-1:0] col, input int limit,
                              output int n_exp, output bit oob);
        pix_t p;
        n_exp = 0;
`ifdef FILL_CLIP_EN
        oob = 1'b0;
`else
        oob = (x0 + w > HMAX) || (y0 + h > VMAX);
        if (oob) return;
`endif
        for (int y = y0; y < y0 + h; y++) begin
            for (int x = x0; x < x0 + w; x++) begin
                if (limit >= 0 && n_exp >= limit) return;
                if (x < HMAX && y < VMAX) begin
                    p.addr = {1'b1, 20'(y * HMAX + x)};
                    p.data = 32'(col);
                    exp_q.push_back(p);
                    n_exp++;
                end
            end
        end
    endtask

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic reg_wr(input logic [1:0] a, input logic [31:0] d);
        fill_cs = 1'b1; fill_wr = 1'b1; fill_addr = a; fill_wr_data = d;
        tick();
        fill_cs = 1'b0; fill_wr = 1'b0;
    endtask

    task automatic reg_rd(input logic [1:0] a, output logic [31:0] d);
        fill_cs = 1'b1; fill_wr = 1'b0; fill_addr = a;
        #1;
        d = fill_rd_data;
        fill_cs = 1'b0;
    endtask

    task automatic go_fill(input int x0, input int y0, input int w, input int h,
                           input logic [DW-1:0] col, input int limit,
                           output int n_exp, output bit oob);
        reg_wr(REG_ORIGIN, {7'b0, 9'(y0), 6'b0, 10'(x0)});
        reg_wr(REG_SIZE,   {7'b0, 9'(h),  6'b0, 10'(w)});
        reg_wr(REG_COLOR,  32'(col));
        reg_wr(REG_CTRL,   32'h4);
        model_fill(x0, y0, w, h, col, limit, n_exp, oob);
        reg_wr(REG_CTRL,   32'h1);
    endtask

    task automatic wait_idle(input int budget, input bit rnd_cpu, input string name);
        int k = 0;
        while (busy && k < budget) begin
            cpu_cs      = rnd_cpu && ($urandom_range(0, 3) == 0);
            cpu_wr      = 1'($urandom);
            cpu_addr    = 21'($urandom);
            cpu_wr_data = $urandom;
            tick();
            k++;
        end
        cpu_cs = 1'b0;
        check({name, "_timeout"}, 64'(busy), 64'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got running expected finished");
        $fatal(1);
    end

    initial begin
        logic [31:0] d;
        int          n0, c0, n_exp, x0, y0, w, h;
        bit          oob;
        logic [DW-1:0] col;

        reset_sys = 1'b1;
        cpu_cs = 1'b0; cpu_wr = 1'b0; cpu_addr = '0; cpu_wr_data = '0;
        fill_cs = 1'b0; fill_wr = 1'b0; fill_addr = '0; fill_wr_data = '0;
        repeat (3) tick();
        reset_sys = 1'b0;

        // Reset state
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done_irq), 64'd0);
        check("rst_bus_idle", {video_cs, video_wr}, 64'd0);
        reg_rd(REG_CTRL, d);   check("rst_status", d, 64'd0);
        reg_rd(REG_ORIGIN, d); check("rst_origin", d, 64'd0);
        tick();

        // Basic 3x2 fill with register read-back and first-write latency
        n0 = n_wr;
        go_fill(10, 2, 3, 2, 9'h1AB, -1, n_exp, oob);
        check("setup_no_write", {video_cs, video_wr}, 64'd0);
        reg_rd(REG_ORIGIN, d); check("rd_origin", d, 64'h0002_000A);
        reg_rd(REG_SIZE, d);   check("rd_size", d, 64'h0002_0003);
        tick();
        check("first_write_latency", {video_cs, video_wr}, 64'd3);
        reg_rd(REG_COLOR, d);  check("rd_color", d, 64'h1AB);
        wait_idle(50, 1'b0, "basic");
        check("basic_count", 64'(n_wr - n0), 64'(n_exp));
        check("basic_done", 64'(done_irq), 64'd1);
        reg_rd(REG_CTRL, d);   check("basic_status", d, 64'h2);
        check("basic_queue_empty", 64'(exp_q.size()), 64'd0);

        // Zero-width fill: straight to done, no writes
        n0 = n_wr;
        go_fill(5, 5, 0, 3, 9'h055, -1, n_exp, oob);
        tick();
        check("w0_done_early", 64'(done_irq), 64'd0);
        tick();
        check("w0_done_3cyc", 64'(done_irq), 64'd1);
        check("w0_no_writes", 64'(n_wr - n0), 64'd0);

        // CPU stall for 4 cycles plus register rewrite mid-fill
        n0 = n_wr; c0 = n_cpu;
        go_fill(100, 50, 20, 2, 9'h0F0, -1, n_exp, oob);
        repeat (4) tick();
        for (int i = 0; i < 4; i++) begin
            cpu_cs = 1'b1; cpu_wr = 1'($urandom);
            cpu_addr = 21'($urandom); cpu_wr_data = $urandom;
            tick();
        end
        cpu_cs = 1'b0;
        reg_wr(REG_COLOR, 32'h1FF);
        reg_wr(REG_ORIGIN, 32'h0000_0001);
        wait_idle(200, 1'b0, "stall");
        check("stall_cpu_cycles", 64'(n_cpu - c0), 64'd4);
        check("stall_count", 64'(n_wr - n0), 64'd40);
        check("stall_done", 64'(done_irq), 64'd1);

        // Abort in the cycle of the 5th write of a 100x1 fill
        n0 = n_wr;
        go_fill(0, 10, 100, 1, 9'h033, 5, n_exp, oob);
        repeat (5) tick();
        reg_wr(REG_CTRL, 32'h2);
        check("abort_busy", 64'(busy), 64'd0);
        reg_rd(REG_CTRL, d); check("abort_status", d, 64'h4);
        repeat (10) tick();
        check("abort_count", 64'(n_wr - n0), 64'd5);
        check("abort_queue_empty", 64'(exp_q.size()), 64'd0);

        // Right-edge fill
        n0 = n_wr;
        go_fill(638, 0, 4, 1, 9'h100, -1, n_exp, oob);
        wait_idle(50, 1'b0, "edge");
        repeat (2) tick();
        reg_rd(REG_CTRL, d);
`ifdef FILL_CLIP_EN
        check("edge_count", 64'(n_wr - n0), 64'd2);
        check("edge_status", d, 64'h2);
`else
        check("edge_count", 64'(n_wr - n0), 64'd0);
        check("edge_status", d, 64'h4);
`endif

        // Reset in the middle of a fill
        go_fill(0, 20, 100, 1, 9'h077, -1, n_exp, oob);
        repeat (4) tick();
        reset_sys = 1'b1;
        tick();
        reset_sys = 1'b0;
        exp_q.delete();
        check("midrst_busy", 64'(busy), 64'd0);
        check("midrst_bus_idle", {video_cs, video_wr}, 64'd0);
        reg_rd(REG_CTRL, d); check("midrst_status", d, 64'd0);
        repeat (5) tick();

        // Randomized fills with random CPU interference
        for (int it = 0; it < 30; it++) begin
            x0  = ($urandom_range(0, 3) == 0) ? $urandom_range(HMAX - 8, HMAX - 1) : $urandom_range(0, HMAX - 16);
            y0  = ($urandom_range(0, 3) == 0) ? $urandom_range(VMAX - 3, VMAX - 1) : $urandom_range(0, VMAX - 8);
            w   = $urandom_range(0, 12);
            h   = $urandom_range(0, 4);
            col = DW'($urandom);
            n0  = n_wr;
            go_fill(x0, y0, w, h, col, -1, n_exp, oob);
            wait_idle(400, 1'b1, "rnd");
            tick();
            check("rnd_count", 64'(n_wr - n0), 64'(n_exp));
            reg_rd(REG_CTRL, d);
            check("rnd_status", d, {61'd0, oob, !oob, 1'b0});
            check("rnd_queue_empty", 64'(exp_q.size()), 64'd0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
